seq_detector: RTL and testbench
===============================

# seq_detector

Parametrised Moore-style serial pattern detector, the generalised successor to the fixed 4-bit "1101" Moore detector. Samples one serial bit per qualified clock, compares the most recent PAT_LEN bits against a runtime-loadable pattern and raises a registered match flag. Supports overlapping and non-overlapping detection and an optional saturating match counter. Sits directly behind a serial input synchroniser in the receive datapath.

## Interface
- PAT_LEN, 4, pattern length in bits (2..32)
- PAT_RST, 4'b1101, pattern register reset value (PAT_LEN bits, MSB = first bit received)
- CNT_W, 8, match counter width
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- en  in  1  bit-valid qualifier; `i` is sampled only when `en`=1
- i  in  1  serial data bit
- overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping; sampled with each bit
- load  in  1  synchronous pattern load strobe
- pattern  in  PAT_LEN  new pattern, captured when `load`=1
- o  out  1  match flag (Moore, registered)
- match_count  out  CNT_W  saturating count of matches since reset/load

## Operation
- Internal state: `hist` (PAT_LEN-bit shift register, newest bit in LSB), `fill` (0..PAT_LEN, bits accepted since last restart), `pat` (pattern register).
- Reset: hist=0, fill=0, pat=PAT_RST, o=0, match_count=0.
- Accepted bit (en=1, load=0): hist ← {hist[PAT_LEN-2:0], i}; fill ← min(fill+1, PAT_LEN).
- Match condition: next hist == pat and next fill == PAT_LEN. o ← match condition.
- On match with overlap=0: fill ← 0 (next match needs PAT_LEN fresh bits); hist still updated.
- On match with overlap=1: fill stays PAT_LEN; partial overlap reused.
- en=0: all state held; o holds its previous value (Moore: output is a function of state only).
- load=1: pat ← pattern, hist ← 0, fill ← 0, o ← 0, match_count ← 0. load has priority over en; the bit presented that cycle is discarded.
- match_count increments by 1 on each match, saturates at 2^CNT_W−1, never wraps.

## Timing
- Latency: bit sampled on edge N; o valid after edge N (same edge that shifts in the final pattern bit).
- o remains 1 until the next accepted bit or load; one cycle wide under continuous en.
- match_count updates on the same edge as o.
- Reset asserted mid-stream: all state cleared immediately, regardless of clk; first post-release match requires PAT_LEN accepted bits.
- No handshake back-pressure; every en=1 cycle consumes a bit.

## Configuration
- SEQ_DET_COUNT_EN defined: match counter present as described.
- Undefined: counter logic removed, match_count tied to 0; o behaviour unchanged.

## Structure
- Package `seq_det_pkg`: default PAT_LEN, PAT_RST, CNT_W constants and the `fill` width function ($clog2(PAT_LEN+1)).
- One sub-module: `sat_counter` (CNT_W-bit, inc/clear inputs, saturating), instantiated only under SEQ_DET_COUNT_EN.

## Test plan
- Reset: n_rst=0 mid-clock with i toggling -> o=0, match_count=0 immediately and through a held clock cycle; still 0 after release.
- Default pattern, bits 1,1,0,1 -> o=1 after 4th edge, match_count=1; 1,1,0,0 and 0,0,0,1 -> o=0, count 0.
- Overlap: overlap=1, bits 1,1,0,1,1,0,1 -> o=1 after bits 4 and 7, count=2; overlap=0 same stream -> o=1 only after bit 4, count=1.
- Gaps: 1,1,(en=0 ×3),0,1 -> o=1 after final bit; o held 1 while en=0 afterwards.
- Load: load pattern=4'b0110 while en=1 -> bit discarded, count=0; then 0,1,1,0 -> o=1, count=1; 1,1,0,1 -> o=0.
- Saturation (SEQ_DET_COUNT_EN, CNT_W=2): overlap=1, stream 1101 repeated 5 times -> match_count stops at 3; without macro match_count=0 throughout.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults, decode type and sizing helper for the
// parametrised serial pattern detector.
package seq_det_pkg;

    localparam int          DEF_PAT_LEN = 4;
    localparam logic [31:0] DEF_PAT_RST = 32'b1101;
    localparam int          DEF_CNT_W   = 8;

    // What the detector does with the current cycle.
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_SHIFT = 2'd1,
        ACT_LOAD  = 2'd2
    } det_action_t;

    // Bits needed to hold a fill level in the range 0..pat_len.
    function automatic int fill_width(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/seq_detector_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping.
// A synchronous clear takes priority over an increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    // Count increments, holding at the maximum value once reached.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector.sv
// seq_detector: Moore serial pattern detector. Keeps the last PAT_LEN
// accepted bits and a fill level, and raises a registered match flag when
// the history equals the loadable pattern after PAT_LEN fresh bits.
// Optional feature: define SEQ_DET_COUNT_EN to include the saturating
// match counter; otherwise match_count is tied to zero.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PAT_RST = PAT_LEN'(DEF_PAT_RST),
    parameter int                 CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               en,
    input  logic               i,
    input  logic               overlap,
    input  logic               load,
    input  logic [PAT_LEN-1:0] pattern,
    output logic               o,
    output logic [CNT_W-1:0]   match_count
);

    localparam int             FW        = fill_width(PAT_LEN);
    localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [PAT_LEN-1:0] pat_q,  pat_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [FW-1:0]      fill_inc;
    logic               o_q,    o_d;
    logic               match;
    det_action_t        action;

    assign action = load ? ACT_LOAD : (en ? ACT_SHIFT : ACT_HOLD);

    // State register: history, fill level, pattern and the match flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PAT_RST;
            o_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            o_q    <= o_d;
        end
    end

    // Next state: load restarts everything, an accepted bit shifts and tests.
    always_comb begin
        hist_d   = hist_q;
        fill_d   = fill_q;
        pat_d    = pat_q;
        o_d      = o_q;
        match    = 1'b0;
        fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FW'(1);
        case (action)
            ACT_LOAD: begin
                pat_d  = pattern;
                hist_d = '0;
                fill_d = '0;
                o_d    = 1'b0;
            end
            ACT_SHIFT: begin
                hist_d = {hist_q[PAT_LEN-2:0], i};
                match  = (hist_d == pat_q) && (fill_inc == FILL_FULL);
                o_d    = match;
                fill_d = (match && !overlap) ? '0 : fill_inc;
            end
            default: begin
                hist_d = hist_q;
            end
        endcase
    end

    // Output: the flag comes straight from its register.
    always_comb begin
        o = o_q;
    end

`ifdef SEQ_DET_COUNT_EN
    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (match),
        .clear (load),
        .count (match_count)
    );
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector: directed checks of reset, default pattern, overlap modes,
// en gaps, runtime pattern load and counter saturation (CNT_W=2).
module tb_seq_detector;

    logic       tb_clk;
    logic       n_rst;
    logic       en;
    logic       i;
    logic       overlap;
    logic       load;
    logic [3:0] pattern;
    logic       o;
    logic [1:0] match_count;

    int checks;
    int failures;

    seq_detector #(
        .PAT_LEN (4),
        .PAT_RST (4'b1101),
        .CNT_W   (2)
    ) dut (
        .clk         (tb_clk),
        .n_rst       (n_rst),
        .en          (en),
        .i           (i),
        .overlap     (overlap),
        .load        (load),
        .pattern     (pattern),
        .o           (o),
        .match_count (match_count)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // Expected counter value after n matches with a 2-bit saturating counter.
    function automatic logic [1:0] exp_cnt(input int n);
`ifdef SEQ_DET_COUNT_EN
        return (n > 3) ? 2'd3 : 2'(n);
`else
        return 2'd0;
`endif
    endfunction

    task automatic apply_reset();
        @(negedge tb_clk);
        n_rst = 1'b0;
        en    = 1'b0;
        load  = 1'b0;
        @(negedge tb_clk);
        n_rst = 1'b1;
    endtask

    // One cycle of stimulus; returns 1 time unit after the rising edge.
    task automatic drive(input logic e, input logic b, input logic ov,
                         input logic ld, input logic [3:0] p);
        @(negedge tb_clk);
        en      = e;
        i       = b;
        overlap = ov;
        load    = ld;
        pattern = p;
        @(posedge tb_clk);
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] bits = 4'b1101;
        apply_reset();
        for (int k = 3; k >= 0; k--) drive(1'b1, bits[k], 1'b1, 1'b0, 4'b0);
        checks++;
        if (o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_prematch_o: got %b want 1", o);
        end
        #1;
        n_rst = 1'b0;
        i     = ~i;
        #1;
        checks++;
        if (o !== 1'b0 || match_count !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_async: o=%b cnt=%0d want 0/0", o, match_count);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge tb_clk);
            i = ~i;
            @(posedge tb_clk);
            #1;
            checks++;
            if (o !== 1'b0 || match_count !== 2'd0) begin
                failures++;
                $display("[TB] FAIL reset_held: o=%b cnt=%0d want 0/0", o, match_count);
            end
        end
        @(negedge tb_clk);
        n_rst = 1'b1;
        en    = 1'b0;
        #1;
        checks++;
        if (o !== 1'b0 || match_count !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_release: o=%b cnt=%0d want 0/0", o, match_count);
        end
        for (int k = 3; k >= 0; k--) begin
            drive(1'b1, bits[k], 1'b1, 1'b0, 4'b0);
            checks++;
            if (o !== (k == 0)) begin
                failures++;
                $display("[TB] FAIL reset_first_match bit%0d: o=%b want %b", 3 - k, o, (k == 0));
            end
        end
    endtask

    task automatic test_default_pattern();
        logic [3:0] streams [3] = '{4'b1101, 4'b1100, 4'b0001};
        logic [3:0] exp_o   [3] = '{4'b0001, 4'b0000, 4'b0000};
        int         exp_n   [3] = '{1, 0, 0};
        logic [3:0] s;
        logic [3:0] e;
        for (int t = 0; t < 3; t++) begin
            apply_reset();
            s = streams[t];
            e = exp_o[t];
            for (int k = 3; k >= 0; k--) begin
                drive(1'b1, s[k], 1'b1, 1'b0, 4'b0);
                checks++;
                if (o !== e[k]) begin
                    failures++;
                    $display("[TB] FAIL default_%b bit%0d: o=%b want %b", s, 3 - k, o, e[k]);
                end
            end
            checks++;
            if (match_count !== exp_cnt(exp_n[t])) begin
                failures++;
                $display("[TB] FAIL default_%b count: got %0d want %0d", s, match_count, exp_cnt(exp_n[t]));
            end
        end
    endtask

    task automatic test_overlap();
        logic [6:0] bits = 7'b1101101;
        logic [6:0] e;
        for (int ov = 1; ov >= 0; ov--) begin
            apply_reset();
            e = (ov == 1) ? 7'b0001001 : 7'b0001000;
            for (int k = 6; k >= 0; k--) begin
                drive(1'b1, bits[k], 1'(ov), 1'b0, 4'b0);
                checks++;
                if (o !== e[k]) begin
                    failures++;
                    $display("[TB] FAIL overlap%0d bit%0d: o=%b want %b", ov, 6 - k, o, e[k]);
                end
            end
            checks++;
            if (match_count !== exp_cnt((ov == 1) ? 2 : 1)) begin
                failures++;
                $display("[TB] FAIL overlap%0d count: got %0d want %0d", ov, match_count, exp_cnt((ov == 1) ? 2 : 1));
            end
        end
    endtask

    task automatic test_gaps();
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0);
            checks++;
            if (o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL gap_idle%0d: o=%b want 0", k, o);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0);
        checks++;
        if (o !== 1'b1 || match_count !== exp_cnt(1)) begin
            failures++;
            $display("[TB] FAIL gap_match: o=%b cnt=%0d want 1/%0d", o, match_count, exp_cnt(1));
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0);
            checks++;
            if (o !== 1'b1 || match_count !== exp_cnt(1)) begin
                failures++;
                $display("[TB] FAIL gap_hold%0d: o=%b cnt=%0d want 1/%0d", k, o, match_count, exp_cnt(1));
            end
        end
    endtask

    task automatic test_load();
        logic [6:0] bits  = 7'b1100110;
        logic [6:0] e     = 7'b0000001;
        logic [3:0] tail  = 4'b1101;
        apply_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0110);
        checks++;
        if (o !== 1'b0 || match_count !== 2'd0) begin
            failures++;
            $display("[TB] FAIL load_clear: o=%b cnt=%0d want 0/0", o, match_count);
        end
        for (int k = 6; k >= 0; k--) begin
            drive(1'b1, bits[k], 1'b0, 1'b0, 4'b0);
            checks++;
            if (o !== e[k]) begin
                failures++;
                $display("[TB] FAIL load_new bit%0d: o=%b want %b", 6 - k, o, e[k]);
            end
        end
        checks++;
        if (match_count !== exp_cnt(1)) begin
            failures++;
            $display("[TB] FAIL load_count: got %0d want %0d", match_count, exp_cnt(1));
        end
        for (int k = 3; k >= 0; k--) begin
            drive(1'b1, tail[k], 1'b0, 1'b0, 4'b0);
            checks++;
            if (o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL load_old_pattern bit%0d: o=%b want 0", 3 - k, o);
            end
        end
    endtask

    task automatic test_saturation();
        logic [3:0] bits = 4'b1101;
        int         n    = 0;
        apply_reset();
        for (int r = 0; r < 5; r++) begin
            for (int k = 3; k >= 0; k--) begin
                drive(1'b1, bits[k], 1'b1, 1'b0, 4'b0);
                if (k == 0) n++;
                checks++;
                if (o !== (k == 0) || match_count !== exp_cnt(n)) begin
                    failures++;
                    $display("[TB] FAIL sat rep%0d bit%0d: o=%b cnt=%0d want %b/%0d", r, 3 - k, o, match_count, (k == 0), exp_cnt(n));
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n_rst    = 1'b0;
        en       = 1'b0;
        i        = 1'b0;
        overlap  = 1'b0;
        load     = 1'b0;
        pattern  = 4'b0;
        #1;
        checks++;
        if (o !== 1'b0 || match_count !== 2'd0) begin
            failures++;
            $display("[TB] FAIL power_on_reset: o=%b cnt=%0d want 0/0", o, match_count);
        end
        test_reset();
        test_default_pattern();
        test_overlap();
        test_gaps();
        test_load();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
